// File: rtl/tlm_get_responder.sv
// tlm_get_responder
// Provider side of a TLM-style get interface. Items pushed by a producer are
// buffered in a small FIFO and handed to a consumer that issues GET, TRY_GET,
// PEEK, TRY_PEEK and CAN_GET requests over a request/response handshake.
// GET (and PEEK when enabled) block on an empty buffer until an item arrives.
// Optional feature macro: TLM_GET_RESPONDER_PEEK_EN enables PEEK/TRY_PEEK;
// without it opcodes 2 and 3 answer immediately as reserved operations.

module tlm_get_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       put_valid,
    input  logic [DATA_W-1:0]          put_data,
    output logic                       put_ready,
    input  logic                       req_valid,
    input  logic [2:0]                 req_op,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic                       rsp_ok,
    output logic [DATA_W-1:0]          rsp_data,
    input  logic                       rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [2:0] OP_GET      = 3'd0;
    localparam logic [2:0] OP_TRY_GET  = 3'd1;
`ifdef TLM_GET_RESPONDER_PEEK_EN
    localparam logic [2:0] OP_PEEK     = 3'd2;
    localparam logic [2:0] OP_TRY_PEEK = 3'd3;
`endif
    localparam logic [2:0] OP_CAN_GET  = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic              r_rspOk;
    logic [DATA_W-1:0] r_rspData;

    logic              w_push;
    logic              w_pop;
    logic              w_nonEmpty;
    logic [2:0]        w_opSel;
    logic              w_isGet;
    logic              w_isPeek;
    logic              w_blocking;
    logic              w_accept;
    logic              w_toWait;
    logic              w_load;
    logic              w_rspDone;
    logic              w_nextOk;
    logic [DATA_W-1:0] w_nextData;
    logic [DATA_W-1:0] w_head;

    assign put_ready  = (r_count != FULL_COUNT);
    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_ok     = r_rspOk;
    assign rsp_data   = r_rspData;
    assign level      = r_count;
    assign w_head     = r_mem[r_rdPtr];
    assign w_nonEmpty = (r_count != '0);
    assign w_push     = put_valid && put_ready;

    // Decode the active opcode (live request in IDLE, latched one while
    // blocked) and decide whether this cycle loads a response and/or pops.
    always_comb begin
        w_opSel    = (r_state == S_IDLE) ? req_op : r_op;
        w_isGet    = (w_opSel == OP_GET) || (w_opSel == OP_TRY_GET);
`ifdef TLM_GET_RESPONDER_PEEK_EN
        w_isPeek   = (w_opSel == OP_PEEK) || (w_opSel == OP_TRY_PEEK);
        w_blocking = (w_opSel == OP_GET) || (w_opSel == OP_PEEK);
`else
        w_isPeek   = 1'b0;
        w_blocking = (w_opSel == OP_GET);
`endif
        w_accept   = (r_state == S_IDLE) && req_valid;
        w_toWait   = w_accept && w_blocking && !w_nonEmpty;
        w_load     = (w_accept && !w_toWait) || ((r_state == S_WAIT) && w_nonEmpty);
        w_pop      = w_load && w_isGet && w_nonEmpty;
        w_rspDone  = (r_state == S_RESP) && rsp_ready;
        w_nextOk   = 1'b0;
        w_nextData = '0;
        if ((w_isGet || w_isPeek) && w_nonEmpty) begin
            w_nextOk   = 1'b1;
            w_nextData = w_head;
        end else if (w_opSel == OP_CAN_GET) begin
            w_nextOk   = w_nonEmpty;
        end
    end

    // Buffer storage; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= put_data;
        end
    end

    // Pointers and occupancy; a simultaneous put and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Request/response state machine; the opcode is latched on acceptance so
    // a blocked request remembers what to do once an item shows up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_toWait) begin
                        r_state <= S_WAIT;
                    end else if (w_accept) begin
                        r_state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (w_nonEmpty) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response registers: loaded when entering RESP, held until the consumer
    // takes them, then cleared so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rspOk   <= 1'b0;
            r_rspData <= '0;
        end else if (w_load) begin
            r_rspOk   <= w_nextOk;
            r_rspData <= w_nextData;
        end else if (w_rspDone) begin
            r_rspOk   <= 1'b0;
            r_rspData <= '0;
        end
    end

endmodule
